seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit 7-segment display.
- Holds one 4-bit hex code per digit and sequences one shared seg7_decoder across all digits, one digit slot at a time.
- Drives the common segment bus and the per-digit anode enables.
- Inserts an anti-ghosting blank interval at the start of each slot.
- Accepts new display data over a valid/ready handshake and commits it only at frame boundaries, so the display never tears.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 37 +++
 rtl/seg7_scan_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
package seg7_pkg;

  localparam logic [6:0]  SEG_OFF_AH = 7'h00;
  localparam logic [6:0]  SEG_OFF_AL = 7'h7F;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_t;

  // One-hot anode pattern for digit idx, inverted when the anodes are active-low.
  function automatic logic [MAX_DIGITS-1:0] an_onehot(input int unsigned idx,
                                                      input logic        active_low);
    logic [MAX_DIGITS-1:0] oh;
    oh = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to 7-segment pattern (bit order gfedcba), selectable polarity.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       seg_type,
  output logic [6:0] seg
);

  logic [6:0] pat;

  // Active-high glyph table, inverted for active-low segment drivers.
  always_comb begin
    pat = 7'h00;
    case (hex)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    seg = seg_type ? ~pat : pat;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with tear-free frame commit.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned BLANK_CYC     = 500,
  parameter int unsigned SEG_TYPE      = 1,
  parameter int unsigned AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [4*NUM_DIGITS-1:0] ld_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic                  SEG_AL  = (SEG_TYPE != 0);
  localparam logic                  AN_AL   = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = SEG_AL ? SEG_OFF_AL : SEG_OFF_AH;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_AL ? '1 : '0;

  localparam scan_state_t STATE_INIT = (BLANK_CYC > 0) ? S_BLANK : S_DRIVE;

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [IDX_W-1:0]        idx;
  scan_state_t             state;
  logic [4*NUM_DIGITS-1:0] disp_buf;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic                    slot_last;
  logic                    frame_last;
  logic [3:0]              nib;
  logic                    dig_masked;
  logic [6:0]              dec_seg;
  logic [MAX_DIGITS-1:0]   an_sel;

  // Slot/frame boundary detection and next prescaler value.
  always_comb begin
    slot_last  = (cnt == CNT_LAST);
    frame_last = slot_last && (idx == IDX_LAST);
    cnt_next   = slot_last ? '0 : cnt + 1'b1;
  end

  // Select the current digit's nibble and live blank bit; anode pattern for idx.
  always_comb begin
    nib        = '0;
    dig_masked = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib        = disp_buf[4*k +: 4];
        dig_masked = blank_mask[k];
      end
    end
    an_sel = an_onehot(32'(idx), AN_AL);
  end

  seg7_decoder u_dec (
    .hex      (nib),
    .seg_type (SEG_AL),
    .seg      (dec_seg)
  );

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      if (slot_last) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Scan FSM: state tracks the blank/drive phase of cnt; seg/an are registered one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_INIT;
      seg   <= SEG_OFF;
      an    <= AN_OFF;
    end else begin
      state <= (cnt_next < BLANK_END) ? S_BLANK : S_DRIVE;
      if (state == S_DRIVE && !dig_masked) begin
        seg <= dec_seg;
        an  <= an_sel[NUM_DIGITS-1:0];
      end else begin
        seg <= SEG_OFF;
        an  <= AN_OFF;
      end
    end
  end

  // Load handshake into the shadow word; commit to the display buffer only at the frame boundary.
  // A word accepted on the boundary cycle itself has pending=0 there, so it waits a full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_buf <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
      ld_ready <= 1'b1;
    end else if (frame_last && pending) begin
      disp_buf <= shadow;
      pending  <= 1'b0;
      ld_ready <= 1'b1;
    end else if (ld_valid && ld_ready) begin
      shadow   <= ld_data;
      pending  <= 1'b1;
      ld_ready <= 1'b0;
    end
  end

  a_an_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(an ^ AN_OFF));
  a_ready_pending: assert property (@(posedge clk) disable iff (rst) ld_ready == !pending);

endmodule
